spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on sclk, cs_n and mosi (legal values 2..3).
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- spi_sclk  in  1  host SPI clock, mode 0, asynchronous to clk.
- spi_cs_n  in  1  host chip select, active-low, asynchronous.
- spi_mosi  in  1  host serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- spi_miso_oe  out  1  MISO output enable.
- reg_addr  out  8  register address.
- reg_wdata  out  32  register write data.
- reg_write  out  1  one-cycle write strobe.
- reg_read  out  1  one-cycle read strobe.
- reg_rdata  in  32  read data, valid 1 clk after reg_read.
- busy  out  1  a transaction is in progress.
- txn_err  out  1  one-cycle pulse on an aborted or illegal transaction.

Function
REQ-003 The block SHALL pass spi_sclk, spi_cs_n and spi_mosi through SYNC_STAGES flops, then detect sclk rise and fall edges from the synchronized value and its one-cycle delay.
REQ-004 Supported sclk frequency SHALL be at most clk/8 (each sclk half-period at least 4 clk); behaviour above this is undefined.
REQ-005 Transaction format SHALL be: 8-bit opcode, then 8-bit address, then 32 data bits, all MSB first and 48 sclk rising edges in total; opcode 0x02 = write, 0x03 = read.
REQ-006 Bits SHALL be sampled from synchronized mosi on the detected sclk rise and counted by a 6-bit counter (0..47).
REQ-007 The FSM SHALL have states IDLE, CMD, ADDR, RD_WAIT, WR_DATA, RD_DATA, COMMIT, DRAIN.
REQ-008 IDLE->CMD SHALL occur when synchronized cs_n falls; the bit counter and shift register clear on that transition.
REQ-009 CMD->ADDR SHALL occur after the 8th rise; if the opcode is neither 0x02 nor 0x03, the FSM SHALL go to DRAIN and pulse txn_err.
REQ-010 ADDR SHALL latch reg_addr after the 16th rise, then go to WR_DATA (write) or RD_WAIT (read).
REQ-011 RD_WAIT SHALL pulse reg_read for exactly 1 clk in the cycle after the address latch, capture reg_rdata into the 32-bit TX shift register on the following clk, then go to RD_DATA.
REQ-012 In RD_DATA, spi_miso SHALL present TX bit 31 immediately on load, then shift left on each detected sclk fall; after the 48th rise the FSM SHALL go to DRAIN.
REQ-013 spi_miso_oe SHALL be 1 only in RD_WAIT and RD_DATA, otherwise 0; spi_miso SHALL be 0 whenever spi_miso_oe is 0.
REQ-014 WR_DATA SHALL shift 32 mosi bits into reg_wdata; after the 48th rise the FSM SHALL go to COMMIT.
REQ-015 COMMIT SHALL assert reg_write for exactly 1 clk with reg_addr and reg_wdata stable, then go to DRAIN.
REQ-016 reg_addr and reg_wdata SHALL hold their value until overwritten by the next transaction.
REQ-017 DRAIN SHALL ignore sclk edges and return to IDLE when synchronized cs_n is high.
REQ-018 If cs_n rises in CMD, ADDR, WR_DATA, RD_WAIT or RD_DATA, the FSM SHALL go to IDLE and pulse txn_err for 1 clk.
REQ-019 An abort in WR_DATA SHALL NOT assert reg_write.
REQ-020 An abort in RD_WAIT after reg_read has pulsed SHALL discard the captured data.
REQ-021 Extra sclk edges beyond 48 before cs_n rises SHALL be ignored, with no second strobe.
REQ-022 reg_read and reg_write SHALL never be asserted in the same cycle, and each SHALL be asserted at most once per transaction.
REQ-023 busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 With rst_n low at a clk edge, the FSM SHALL enter IDLE; reg_addr=0x00, reg_wdata=0x00000000, reg_write=0, reg_read=0, spi_miso=0, spi_miso_oe=0, busy=0, txn_err=0; counters, shift registers and synchronizer flops clear, with the sync cs_n flops set to 1.
REQ-025 Reset asserted mid-transaction SHALL abort with no strobe and no txn_err; after release the FSM SHALL wait in IDLE for a fresh cs_n fall, ignoring a cs_n already low.

Verification
REQ-026 Write: cs_n low, send 0x02, 0x0E, 0x000000C8, then cs_n high -> single reg_write pulse with reg_addr=0x0E and reg_wdata=0x000000C8; txn_err stays 0.
REQ-027 Read: send 0x03, 0x17 with rdata model returning 0x56313030 one clk after reg_read -> exactly one reg_read pulse; MISO bits 16..47 = 0x56313030; spi_miso_oe high only during the data phase.
REQ-028 Bad opcode: send 0x55 then 40 more bits -> txn_err pulses once after bit 8; no reg_read or reg_write; spi_miso_oe stays 0.
REQ-029 Abort: write transaction with cs_n raised after bit 30 -> txn_err pulse, no reg_write, FSM in IDLE, busy=0; the next valid write commits correctly.
REQ-030 Reset mid-read: assert rst_n low during RD_DATA -> all outputs at reset values; after release, a read of 0x01 completes correctly.
REQ-031 Back-to-back: two writes with cs_n high for only 4 clk between them at sclk = clk/8 -> two reg_write pulses, each with the correct addr and data.

Source files
------------

// File: rtl/spi_reg_bridge_if.sv
// SPI pins and register-bus handshake for spi_reg_bridge.
// The bridge uses the slave view; the host/register side uses the master view.
interface spi_reg_bridge_if;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_write;
    logic        reg_read;
    logic [31:0] reg_rdata;
    logic        busy;
    logic        txn_err;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, reg_rdata,
        output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_write, reg_read, busy, txn_err
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, reg_rdata,
        input  spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_write, reg_read, busy, txn_err
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 48-bit opcode/address/data frames into
// single-cycle register read and write strobes.
module spi_reg_bridge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_reg_bridge_if.slave  bus
);
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam logic [7:0]       OP_WR     = 8'h02;
    localparam logic [7:0]       OP_RD     = 8'h03;
    localparam logic [CNT_W-1:0] CNT_OP    = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(15);
    localparam logic [CNT_W-1:0] CNT_SHIFT = CNT_W'(17);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(47);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, RD_WAIT, WR_DATA, RD_DATA, COMMIT, DRAIN
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, vld_q;
    logic                   sclk_prev_q, cs_prev_q, armed_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rx_q, rx_d, rx_shift;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                is_rd_q, is_rd_d;
    logic [1:0]          ph_q, ph_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d, read_q, read_d;
    logic                miso_q, miso_d, oe_q, oe_d;
    logic                busy_q, busy_d, err_q, err_d;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // armed_q blocks a cs_n that was already low when reset released
    assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
    assign rx_shift  = {rx_q[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            is_rd_q     <= 1'b0;
            ph_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            armed_q     <= armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            is_rd_q     <= is_rd_d;
            ph_q        <= ph_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            read_q      <= read_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        is_rd_d = is_rd_q;
        ph_d    = ph_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = 1'b0;
        read_d  = 1'b0;
        err_d   = 1'b0;

        if (sclk_rise && (state_q inside {CMD, ADDR, RD_WAIT, WR_DATA, RD_DATA})) begin
            cnt_d = cnt_q + CNT_W'(1);
            rx_d  = rx_shift;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    rx_d    = '0;
                end
            end
            CMD: begin
                if (cs_s) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (sclk_rise && cnt_q == CNT_OP) begin
                    if (rx_shift[7:0] == OP_WR || rx_shift[7:0] == OP_RD) begin
                        state_d = ADDR;
                        is_rd_d = (rx_shift[7:0] == OP_RD);
                    end else begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (cs_s) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (sclk_rise && cnt_q == CNT_ADDR) begin
                    addr_d  = rx_shift[ADDR_W-1:0];
                    ph_d    = '0;
                    state_d = is_rd_q ? RD_WAIT : WR_DATA;
                end
            end
            // phase 0 strobes reg_read, phase 2 samples reg_rdata one clk after the strobe
            RD_WAIT: begin
                if (cs_s) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    tx_d    = '0;
                end else begin
                    case (ph_q)
                        2'd0: begin
                            read_d = 1'b1;
                            ph_d   = 2'd1;
                        end
                        2'd1: ph_d = 2'd2;
                        default: begin
                            tx_d    = bus.reg_rdata;
                            state_d = RD_DATA;
                        end
                    endcase
                end
            end
            WR_DATA: begin
                if (cs_s) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (sclk_rise && cnt_q == CNT_LAST) begin
                    wdata_d = rx_shift;
                    write_d = 1'b1;
                    state_d = COMMIT;
                end
            end
            // bit 31 stays on MISO through the first data rise; shifting starts on the fall after it
            RD_DATA: begin
                if (cs_s) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    tx_d    = '0;
                end else if (sclk_rise && cnt_q == CNT_LAST) begin
                    state_d = DRAIN;
                end else if (sclk_fall && cnt_q >= CNT_SHIFT) begin
                    tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end
            end
            COMMIT: state_d = DRAIN;
            DRAIN: begin
                if (cs_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        oe_d   = (state_d == RD_WAIT) || (state_d == RD_DATA);
        miso_d = (state_d == RD_DATA) && tx_d[DATA_W-1];
        busy_d = (state_d != IDLE);
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.reg_addr    = addr_q;
    assign bus.reg_wdata   = wdata_q;
    assign bus.reg_write   = write_q;
    assign bus.reg_read    = read_q;
    assign bus.busy        = busy_q;
    assign bus.txn_err     = err_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: a table of SPI frames with expected strobes,
// errors and MISO words, plus sequences for back-to-back writes and mid-read reset.
module tb_spi_reg_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_reg_bridge_if bus();

    spi_reg_bridge #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  addr;
        logic [31:0] data;
        int          nbits;
        int          exp_wr;
        int          exp_rd;
        int          exp_err;
        logic [31:0] exp_miso;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int n_chk = 0;
    int n_fail = 0;
    int n_wr = 0, n_rd = 0, n_err = 0, n_oe = 0, n_anom = 0;
    int tb_bits = 0;
    logic [7:0]  wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    logic [31:0] rd_val = 32'h0;

    // Register-side model: read data is valid exactly one clk after reg_read
    always @(posedge clk) bus.reg_rdata <= bus.reg_read ? rd_val : 32'hBAD0_BAD0;

    // Event monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.reg_write) begin
                n_wr++;
                wr_addr_log.push_back(bus.reg_addr);
                wr_data_log.push_back(bus.reg_wdata);
            end
            if (bus.reg_read) n_rd++;
            if (bus.txn_err) n_err++;
            if (bus.spi_miso_oe) n_oe++;
            if (bus.spi_miso_oe && tb_bits < 16) n_anom++;
            if (!bus.spi_miso_oe && bus.spi_miso) n_anom++;
            if (bus.reg_write && bus.reg_read) n_anom++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " reg_addr"},    32'(bus.reg_addr),    32'h0);
        check({tag, " reg_wdata"},   bus.reg_wdata,        32'h0);
        check({tag, " reg_write"},   32'(bus.reg_write),   32'h0);
        check({tag, " reg_read"},    32'(bus.reg_read),    32'h0);
        check({tag, " spi_miso"},    32'(bus.spi_miso),    32'h0);
        check({tag, " spi_miso_oe"}, 32'(bus.spi_miso_oe), 32'h0);
        check({tag, " busy"},        32'(bus.busy),        32'h0);
        check({tag, " txn_err"},     32'(bus.txn_err),     32'h0);
    endtask

    // Host side: mode 0, half-period 4 clk, MISO sampled just before each rise
    task automatic send_bits(input logic [47:0] w, input int nbits, output logic [31:0] miso_w);
        miso_w = '0;
        for (int b = 0; b < nbits; b++) begin
            int idx;
            idx = 47 - b;
            bus.spi_mosi = (idx >= 0) ? w[idx] : 1'b0;
            repeat (4) @(negedge clk);
            if (b >= 16 && b < 48) miso_w = {miso_w[30:0], bus.spi_miso};
            bus.spi_sclk = 1'b1;
            tb_bits = b + 1;
            repeat (4) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [7:0] addr, input logic [31:0] data,
                           input int nbits, input int gap, output logic [31:0] miso_w);
        tb_bits = 0;
        bus.spi_cs_n = 1'b0;
        send_bits({op, addr, data}, nbits, miso_w);
        repeat (4) @(negedge clk);
        bus.spi_cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int b_wr, b_rd, b_err, b_oe, b_anom, q0;
        logic [31:0] mw;

        vecs[0] = '{8'h02, 8'h0E, 32'h0000_00C8, 48, 1, 0, 0, 32'h0};
        vecs[1] = '{8'h03, 8'h17, 32'h5631_3030, 48, 0, 1, 0, 32'h5631_3030};
        vecs[2] = '{8'h55, 8'h00, 32'h0000_0000, 48, 0, 0, 1, 32'h0};
        vecs[3] = '{8'h02, 8'h33, 32'h1234_5678, 30, 0, 0, 1, 32'h0};
        vecs[4] = '{8'h02, 8'hA5, 32'hFFFF_0001, 48, 1, 0, 0, 32'h0};
        vecs[5] = '{8'h03, 8'h01, 32'h8000_0001, 48, 0, 1, 0, 32'h8000_0001};
        vecs[6] = '{8'h02, 8'h5A, 32'hA5A5_A5A5, 52, 1, 0, 0, 32'h0};
        vecs[7] = '{8'h03, 8'h42, 32'h0000_0000, 12, 0, 0, 1, 32'h0};
        vecs[8] = '{8'h03, 8'h42, 32'hCAFE_F00D, 30, 0, 1, 1, 32'h0};
        vecs[9] = '{8'h00, 8'h11, 32'h0000_0000, 48, 0, 0, 1, 32'h0};

        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            b_wr = n_wr; b_rd = n_rd; b_err = n_err; b_oe = n_oe; b_anom = n_anom;
            q0 = wr_addr_log.size();
            rd_val = vecs[i].data;
            run_txn(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].nbits, 12, mw);
            check($sformatf("v%0d write count", i), 32'(n_wr - b_wr), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d read count", i),  32'(n_rd - b_rd), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d err count", i),   32'(n_err - b_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d oe seen", i),     32'(n_oe > b_oe), 32'(vecs[i].exp_rd != 0));
            check($sformatf("v%0d anomalies", i),   32'(n_anom - b_anom), 32'h0);
            check($sformatf("v%0d busy idle", i),   32'(bus.busy), 32'h0);
            check($sformatf("v%0d oe idle", i),     32'(bus.spi_miso_oe), 32'h0);
            if (vecs[i].exp_wr == 1 && wr_addr_log.size() > q0) begin
                check($sformatf("v%0d reg_addr", i),  32'(wr_addr_log[q0]), 32'(vecs[i].addr));
                check($sformatf("v%0d reg_wdata", i), wr_data_log[q0], vecs[i].data);
            end
            if (vecs[i].exp_rd == 1 && vecs[i].nbits >= 48)
                check($sformatf("v%0d miso word", i), mw, vecs[i].exp_miso);
        end

        // Back-to-back writes with cs_n high for only 4 clk in between
        b_wr = n_wr; b_err = n_err; q0 = wr_addr_log.size();
        run_txn(8'h02, 8'h10, 32'h1111_1111, 48, 4, mw);
        run_txn(8'h02, 8'h20, 32'h2222_2222, 48, 12, mw);
        check("b2b write count", 32'(n_wr - b_wr), 32'd2);
        check("b2b err count",   32'(n_err - b_err), 32'd0);
        if (wr_addr_log.size() >= q0 + 2) begin
            check("b2b addr 0",  32'(wr_addr_log[q0]),   32'h10);
            check("b2b data 0",  wr_data_log[q0],        32'h1111_1111);
            check("b2b addr 1",  32'(wr_addr_log[q0+1]), 32'h20);
            check("b2b data 1",  wr_data_log[q0+1],      32'h2222_2222);
        end
        check("held reg_wdata", bus.reg_wdata, 32'h2222_2222);

        // Reset during the data phase of a read, with cs_n still low afterwards
        rd_val = 32'h0BAD_CAFE;
        tb_bits = 0;
        bus.spi_cs_n = 1'b0;
        send_bits({8'h03, 8'h77, 32'h0}, 24, mw);
        check("pre-reset oe", 32'(bus.spi_miso_oe), 32'h1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("mid-read reset");
        rst_n = 1'b1;
        b_wr = n_wr; b_rd = n_rd; b_err = n_err;
        send_bits({8'h02, 8'h01, 32'h0}, 8, mw);
        check("stale cs busy", 32'(bus.busy), 32'h0);
        bus.spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post-reset err count",   32'(n_err - b_err), 32'd0);
        check("post-reset strobe count", 32'((n_wr - b_wr) + (n_rd - b_rd)), 32'd0);

        rd_val = 32'h600D_F00D;
        b_rd = n_rd; b_err = n_err;
        run_txn(8'h03, 8'h01, 32'h0, 48, 12, mw);
        check("read01 read count", 32'(n_rd - b_rd), 32'd1);
        check("read01 err count",  32'(n_err - b_err), 32'd0);
        check("read01 miso word",  mw, 32'h600D_F00D);
        check("read01 reg_addr",   32'(bus.reg_addr), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
